mips_main_control_fsm: RTL

//  Multicycle MIPS main control unit. Decodes opcode[5:0] and sequences FETCH/DECODE/EXECUTE/MEM/WB.

---
 rtl/mips_ctrl_pkg.sv | 54 +++++
 rtl/mips_ctrl_outdec.sv | 66 ++++++
 rtl/mips_main_control_fsm.sv | 104 ++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// ALU operation codes, mux selects and the packed datapath control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_word_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Pure combinational map from an FSM state to the datapath control word.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t ctrl
);

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_main_control_fsm.sv
// Multicycle MIPS main control FSM with registered control outputs.
// Define CTRL_JUMP_EN to decode the J instruction; otherwise J is illegal.
module mips_main_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t     state_q, next_state;
    ctrl_word_t ctrl_q, next_ctrl;
    logic       op_legal;

    always_comb begin
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
`ifdef CTRL_JUMP_EN
            OP_J:                           op_legal = 1'b1;
`endif
            default:                        op_legal = 1'b0;
        endcase
    end

    always_comb begin
        next_state = ST_FETCH;
        case (state_q)
            ST_IDLE:   next_state = ST_FETCH;
            ST_FETCH:  next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = ST_MEMADR;
                    OP_RTYPE:     next_state = ST_EXEC;
                    OP_BEQ:       next_state = ST_BRANCH;
`ifdef CTRL_JUMP_EN
                    OP_J:         next_state = ST_JUMP;
`endif
                    default:      next_state = ST_FETCH;
                endcase
            end
            ST_MEMADR: next_state = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  next_state = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  next_state = ST_FETCH;
            ST_MEMWR:  next_state = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   next_state = ST_ALUWB;
            ST_ALUWB:  next_state = ST_FETCH;
            ST_BRANCH: next_state = ST_FETCH;
            ST_JUMP:   next_state = ST_FETCH;
            default:   next_state = ST_FETCH;
        endcase
    end

    // Decoding next_state lets the registered word be valid for the whole state.
    mips_ctrl_outdec u_outdec (
        .state (next_state),
        .ctrl  (next_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= next_state;
            ctrl_q  <= next_ctrl;
        end
    end

    assign alu_op        = ctrl_q.alu_op;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign pc_source     = ctrl_q.pc_source;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;

    // Fetch strobes fire only in the cycle the instruction word actually arrives.
    assign ir_write   = ctrl_q.ir_write & mem_ready;
    assign pc_write   = ctrl_q.pc_write & (mem_ready | (state_q != ST_FETCH));
    assign illegal_op = (state_q == ST_DECODE) & ~op_legal;
    assign state_o    = state_q;

endmodule
